// File: rtl/square_sum_acc.sv
// rtl/square_sum_acc.sv - pipelined sum-of-squares engine with windowed energy accumulation
module square_sum_acc #(
   parameter int CH       = 12,
   parameter int DW       = 24,
   parameter int WIN_LOG2 = 4,
   parameter int OW       = 64
) (
   input  logic                 i_50M_clk,
   input  logic                 i_rst,
   input  logic                 i_valid,
   input  logic signed [DW-1:0] i_data [CH-1:0],
   input  logic                 i_mode,
   input  logic                 i_clear,
   output logic signed [OW-1:0] o_data,
   output logic                 o_valid,
   output logic                 o_overflow,
   output logic                 o_busy
);

   localparam int SQW = 2 * DW;
   localparam int SW  = SQW + $clog2(CH);
   // Working width covers the larger of sum and output plus carry headroom.
   localparam int XW  = ((SW > OW) ? SW : OW) + 2;
   localparam logic [XW-1:0] SAT_MAX = {{(XW-OW+1){1'b0}}, {(OW-1){1'b1}}};

   logic [SQW-1:0]      sq_next [CH-1:0];
   logic [SQW-1:0]      s1_sq   [CH-1:0];
   logic                s1_valid;
   logic                s1_mode;
   logic [SW-1:0]       tree_sum;
   logic [SW-1:0]       s2_sum;
   logic                s2_valid;
   logic                s2_mode;
   logic [OW:0]         acc;
   logic [WIN_LOG2-1:0] cnt;
   logic [XW-1:0]       base;
   logic [XW-1:0]       total;
   logic                sat_hit;
   logic [OW-1:0]       total_sat;
   logic                window_end;

   function automatic logic [SQW-1:0] square(input logic signed [DW-1:0] x);
      logic signed [SQW-1:0] e;
      e = SQW'(x);
      return e * e;
   endfunction

   always_comb begin
      for (int i = 0; i < CH; i++) begin
         sq_next[i] = square(i_data[i]);
      end
   end

   always_comb begin
      tree_sum = '0;
      for (int i = 0; i < CH; i++) begin
         tree_sum = tree_sum + SW'(s1_sq[i]);
      end
   end

   // Mode 0 ignores the accumulator so a pending window is simply dropped.
   always_comb begin
      base       = s2_mode ? XW'(acc) : '0;
      total      = base + XW'(s2_sum);
      sat_hit    = (total > SAT_MAX);
      total_sat  = sat_hit ? SAT_MAX[OW-1:0] : total[OW-1:0];
      window_end = (cnt == '1);
   end

   always_ff @(posedge i_50M_clk) begin
      s1_sq  <= sq_next;
      s2_sum <= tree_sum;
   end

   always_ff @(posedge i_50M_clk or posedge i_rst) begin
      if (i_rst) begin
         s1_valid   <= 1'b0;
         s1_mode    <= 1'b0;
         s2_valid   <= 1'b0;
         s2_mode    <= 1'b0;
         acc        <= '0;
         cnt        <= '0;
         o_data     <= '0;
         o_valid    <= 1'b0;
         o_overflow <= 1'b0;
      end else begin
         o_valid <= 1'b0;
         if (i_clear) begin
            s1_valid   <= 1'b0;
            s2_valid   <= 1'b0;
            acc        <= '0;
            cnt        <= '0;
            o_overflow <= 1'b0;
         end else begin
            s1_valid <= i_valid;
            s1_mode  <= i_mode;
            s2_valid <= s1_valid;
            s2_mode  <= s1_mode;
            if (s2_valid) begin
               if (sat_hit) begin
                  o_overflow <= 1'b1;
               end
               if (!s2_mode || window_end) begin
                  o_data  <= total_sat;
                  o_valid <= 1'b1;
                  acc     <= '0;
                  cnt     <= '0;
               end else begin
                  acc <= {1'b0, total_sat};
                  cnt <= cnt + WIN_LOG2'(1);
               end
            end
         end
      end
   end

   assign o_busy = s1_valid | s2_valid | o_valid | (cnt != '0);

endmodule

// File: tb/tb_square_sum_acc.sv
// tb/tb_square_sum_acc.sv - randomized and directed bench for square_sum_acc against a vector-level model
module tb_square_sum_acc;
   localparam int CH = 12;
   localparam int DW = 24;

   logic clk = 1'b0;
   logic rst, valid, mode, clear;
   logic signed [DW-1:0] din [CH-1:0];
   int stage [CH];

   logic signed [63:0] od0, od1;
   logic signed [15:0] od2;
   logic ov0, ov1, ov2, of0, of1, of2, bz0, bz1, bz2;

   int total = 0;
   int bad   = 0;

   always #10 clk = ~clk;

   square_sum_acc #(.CH(CH), .DW(DW), .WIN_LOG2(4), .OW(64)) u0 (
      .i_50M_clk(clk), .i_rst(rst), .i_valid(valid), .i_data(din), .i_mode(mode), .i_clear(clear),
      .o_data(od0), .o_valid(ov0), .o_overflow(of0), .o_busy(bz0));
   square_sum_acc #(.CH(CH), .DW(DW), .WIN_LOG2(2), .OW(64)) u1 (
      .i_50M_clk(clk), .i_rst(rst), .i_valid(valid), .i_data(din), .i_mode(mode), .i_clear(clear),
      .o_data(od1), .o_valid(ov1), .o_overflow(of1), .o_busy(bz1));
   square_sum_acc #(.CH(CH), .DW(DW), .WIN_LOG2(2), .OW(16)) u2 (
      .i_50M_clk(clk), .i_rst(rst), .i_valid(valid), .i_data(din), .i_mode(mode), .i_clear(clear),
      .o_data(od2), .o_valid(ov2), .o_overflow(of2), .o_busy(bz2));

   typedef struct {
      bit     v;
      bit     m;
      bit     c;
      longint sum;
   } rec_t;

   rec_t   h0, h1, h2;
   int     win  [3] = '{16, 4, 4};
   longint smax [3] = '{64'sh7FFF_FFFF_FFFF_FFFF, 64'sh7FFF_FFFF_FFFF_FFFF, 64'sd32767};
   longint m_acc [3];
   longint m_od  [3];
   int     m_cnt [3];
   bit     m_ov  [3];
   bit     m_of  [3];
   bit     m_bz  [3];
   longint obs0[$], obs1[$], obs2[$];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   function automatic longint sat(input int k, input longint x);
      if (x > smax[k]) begin
         m_of[k] = 1'b1;
         return smax[k];
      end
      return x;
   endfunction

   function automatic void model_reset();
      h0 = '{default: 0};
      h1 = '{default: 0};
      h2 = '{default: 0};
      for (int k = 0; k < 3; k++) begin
         m_acc[k] = 0; m_od[k] = 0; m_cnt[k] = 0;
         m_ov[k] = 0; m_of[k] = 0; m_bz[k] = 0;
      end
   endfunction

   // A vector reaches the output two edges after sampling unless a clear hits any of those three edges.
   function automatic void model_edge(input rec_t r);
      h2 = h1;
      h1 = h0;
      h0 = r;
      for (int k = 0; k < 3; k++) begin
         m_ov[k] = 1'b0;
         if (h0.c) begin
            m_acc[k] = 0; m_cnt[k] = 0; m_of[k] = 1'b0;
         end else if (h2.v && !h2.c && !h1.c) begin
            if (!h2.m) begin
               m_od[k] = sat(k, h2.sum); m_ov[k] = 1'b1;
               m_acc[k] = 0; m_cnt[k] = 0;
            end else if (m_cnt[k] < win[k] - 1) begin
               m_acc[k] = sat(k, m_acc[k] + h2.sum);
               m_cnt[k]++;
            end else begin
               m_od[k] = sat(k, m_acc[k] + h2.sum); m_ov[k] = 1'b1;
               m_acc[k] = 0; m_cnt[k] = 0;
            end
         end
         m_bz[k] = (h0.v && !h0.c) || (h1.v && !h1.c && !h0.c) || m_ov[k] || (m_cnt[k] != 0);
      end
   endfunction

   task automatic compare_all();
      logic [63:0] gd [3];
      logic        gv [3], gf [3], gb [3];
      gd[0] = od0; gd[1] = od1; gd[2] = {48'd0, od2};
      gv[0] = ov0; gv[1] = ov1; gv[2] = ov2;
      gf[0] = of0; gf[1] = of1; gf[2] = of2;
      gb[0] = bz0; gb[1] = bz1; gb[2] = bz2;
      for (int k = 0; k < 3; k++) begin
         check($sformatf("u%0d_valid t=%0t", k, $time), 64'(gv[k]), 64'(m_ov[k]));
         check($sformatf("u%0d_data t=%0t", k, $time), gd[k], m_od[k]);
         check($sformatf("u%0d_ovf t=%0t", k, $time), 64'(gf[k]), 64'(m_of[k]));
         check($sformatf("u%0d_busy t=%0t", k, $time), 64'(gb[k]), 64'(m_bz[k]));
      end
      if (ov0) obs0.push_back(longint'(od0));
      if (ov1) obs1.push_back(longint'(od1));
      if (ov2) obs2.push_back(longint'({48'd0, od2}));
   endtask

   task automatic step(input bit v, input bit m, input bit c);
      rec_t r;
      r.sum = 0;
      @(negedge clk);
      valid = v; mode = m; clear = c;
      for (int i = 0; i < CH; i++) begin
         din[i] = DW'(stage[i]);
         r.sum += longint'(stage[i]) * longint'(stage[i]);
      end
      r.v = v; r.m = m; r.c = c;
      @(posedge clk);
      #1;
      model_edge(r);
      compare_all();
   endtask

   task automatic fill(input int val);
      for (int i = 0; i < CH; i++) stage[i] = val;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
   endtask

   task automatic flush_obs();
      obs0.delete(); obs1.delete(); obs2.delete();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_d0"}, od0, 64'd0);
      check({tag, "_d1"}, od1, 64'd0);
      check({tag, "_d2"}, {48'd0, od2}, 64'd0);
      check({tag, "_flags"}, {52'd0, ov0, ov1, ov2, of0, of1, of2, bz0, bz1, bz2, 3'd0}, 64'd0);
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      valid = 1'b0; clear = 1'b0;
      #3;
      rst = 1'b1;
      #1;
      check_reset_outputs(tag);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   task automatic rand_data();
      int sel;
      logic signed [DW-1:0] t;
      sel = int'($urandom_range(0, 9));
      for (int i = 0; i < CH; i++) begin
         t = DW'($urandom);
         if (sel < 5)       stage[i] = int'($urandom_range(0, 30)) - 15;
         else if (sel < 9)  stage[i] = int'(t);
         else               stage[i] = t[0] ? -(1 << (DW-1)) : (1 << (DW-1)) - 1;
      end
   endtask

   initial begin
      longint e1 [4] = '{12, 48, 108, 192};
      longint e2 [5] = '{300, 300, 432, 768, 1200};
      rst = 1'b1; valid = 1'b0; mode = 1'b0; clear = 1'b0;
      fill(0);
      for (int i = 0; i < CH; i++) din[i] = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("reset_state");
      @(negedge clk);
      rst = 1'b0;

      flush_obs();
      for (int v = 1; v <= 4; v++) begin fill(v); step(1'b1, 1'b0, 1'b0); end
      idle(4);
      check("t1_count", obs0.size(), 4);
      for (int i = 0; i < 4; i++)
         check($sformatf("t1_val%0d", i), (i < obs0.size()) ? obs0[i] : -1, e1[i]);

      flush_obs();
      fill(-5); step(1'b1, 1'b0, 1'b0);
      idle(3);
      fill(5);  step(1'b1, 1'b0, 1'b0);
      fill(6);  step(1'b1, 1'b0, 1'b0);
      fill(8);  step(1'b1, 1'b0, 1'b0);
      fill(10); step(1'b1, 1'b0, 1'b0);
      idle(4);
      check("t2_count", obs0.size(), 5);
      for (int i = 0; i < 5; i++)
         check($sformatf("t2_val%0d", i), (i < obs0.size()) ? obs0[i] : -1, e2[i]);

      flush_obs();
      fill(1); step(1'b1, 1'b1, 1'b0);
      fill(2); step(1'b1, 1'b1, 1'b0);
      idle(1);
      fill(3); step(1'b1, 1'b1, 1'b0);
      fill(4); step(1'b1, 1'b1, 1'b0);
      idle(4);
      check("t3_count", obs1.size(), 1);
      check("t3_val", (obs1.size() > 0) ? obs1[0] : -1, 360);
      check("t3_busy", 64'(bz1), 64'd0);

      flush_obs();
      fill(1); step(1'b1, 1'b1, 1'b0); step(1'b1, 1'b1, 1'b0);
      fill(2); step(1'b1, 1'b0, 1'b0);
      fill(1); repeat (4) step(1'b1, 1'b1, 1'b0);
      idle(4);
      check("t4_count", obs1.size(), 2);
      check("t4_abort", (obs1.size() > 0) ? obs1[0] : -1, 48);
      check("t4_window", (obs1.size() > 1) ? obs1[1] : -1, 48);

      flush_obs();
      fill(100); step(1'b1, 1'b0, 1'b0);
      fill(1);   step(1'b1, 1'b0, 1'b0);
      idle(4);
      check("t5_sat", (obs2.size() > 0) ? obs2[0] : -1, 32767);
      check("t5_small", (obs2.size() > 1) ? obs2[1] : -1, 12);
      check("t5_sticky", 64'(of2), 64'd1);
      step(1'b0, 1'b0, 1'b1);
      check("t5_cleared", 64'(of2), 64'd0);

      flush_obs();
      fill(3); step(1'b1, 1'b1, 1'b0);
      fill(4); step(1'b1, 1'b0, 1'b0);
      fill(5); step(1'b1, 1'b0, 1'b1);
      idle(4);
      check("t6_none", obs0.size() + obs1.size() + obs2.size(), 0);
      check("t6_idle", {61'd0, bz0, bz1, bz2}, 64'd0);

      flush_obs();
      fill(1); step(1'b1, 1'b1, 1'b0); step(1'b1, 1'b1, 1'b0);
      do_reset("t7_reset");
      idle(5);
      check("t7_none", obs0.size() + obs1.size() + obs2.size(), 0);

      for (int n = 0; n < 3000; n++) begin
         rand_data();
         if ($urandom_range(0, 599) == 0) do_reset("rand_reset");
         step($urandom_range(0, 9) < 7, $urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0);
      end
      idle(4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
